ws2812b_ring_animator: RTL and testbench



---
 rtl/ws2812b_ring_animator.sv | 162 ++++++++++++++++
 tb/tb_ws2812b_ring_animator.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ws2812b_ring_animator.sv
// Frame sequencer feeding the ws2812b_controller write port with an animated ring.
// Optional chase tail when compiled with WS2812B_TAIL_EN.
module ws2812b_ring_animator #(
  parameter int NB_LEDS             = 12,
  parameter int FRAME_PERIOD_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] mode,
  input  logic [7:0] color_r,
  input  logic [7:0] color_g,
  input  logic [7:0] color_b,
  output logic [7:0] address,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       load,
  output logic       latch_n,
  output logic [7:0] position,
  output logic       frame_done
);

  localparam int TW = (FRAME_PERIOD_CYCLES > 2) ?
    $clog2(FRAME_PERIOD_CYCLES) : 1;
  localparam logic [7:0]    LAST   = 8'(NB_LEDS - 1);
  localparam logic [TW-1:0] T_LAST = TW'(FRAME_PERIOD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, GAP, LATCH, WAIT
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [1:0]    cap_mode, cap_mode_nxt;
  logic [23:0]   cap_col, cap_col_nxt;
  logic [7:0]    addr_nxt, pos_nxt;
  logic [23:0]   rgb_nxt;
  logic          load_nxt, latch_nxt, done_nxt, start;

  function automatic logic [7:0] prev_idx(input logic [7:0] p);
    return (p == 8'd0) ? LAST : p - 8'd1;
  endfunction

  function automatic logic [23:0] pix(
    input logic [1:0]  m,
    input logic [23:0] c,
    input logic [7:0]  i,
    input logic [7:0]  p
  );
    logic [23:0] v;
    v = 24'd0;
    case (m)
      2'd0: begin
        if (i == p)
          v = c;
`ifdef WS2812B_TAIL_EN
        else if (i == prev_idx(p))
          v = {1'b0, c[23:17], 1'b0, c[15:9], 1'b0, c[7:1]};
        else if (i == prev_idx(prev_idx(p)))
          v = {2'b0, c[23:18], 2'b0, c[15:10], 2'b0, c[7:2]};
`endif
      end
      2'd1: v = (i <= p) ? c : 24'd0;
      2'd2: v = c;
      default: v = 24'd0;
    endcase
    return v;
  endfunction

  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer + TW'(1);
    cap_mode_nxt = cap_mode;
    cap_col_nxt  = cap_col;
    addr_nxt     = address;
    rgb_nxt      = {red, green, blue};
    pos_nxt      = position;
    load_nxt     = 1'b0;
    latch_nxt    = 1'b1;
    done_nxt     = 1'b0;
    start        = 1'b0;
    case (state)
      IDLE: begin
        timer_nxt = '0;
        addr_nxt  = 8'd0;
        rgb_nxt   = 24'd0;
        start     = enable;
      end
      LOAD: begin
        if (address == LAST) begin
          state_nxt = GAP;
        end else begin
          addr_nxt = address + 8'd1;
          rgb_nxt  = pix(cap_mode, cap_col, addr_nxt, position);
          load_nxt = 1'b1;
        end
      end
      GAP: begin
        state_nxt = LATCH;
        latch_nxt = 1'b0;
      end
      LATCH: begin
        state_nxt = WAIT;
        pos_nxt   = (position == LAST) ? 8'd0 : position + 8'd1;
        done_nxt  = 1'b1;
      end
      WAIT: begin
        if (timer == T_LAST) begin
          if (enable) begin
            start = 1'b1;
          end else begin
            state_nxt = IDLE;
            timer_nxt = '0;
            addr_nxt  = 8'd0;
            rgb_nxt   = 24'd0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Colour/mode are captured here so the whole frame uses one snapshot.
    if (start) begin
      state_nxt    = LOAD;
      timer_nxt    = '0;
      cap_mode_nxt = mode;
      cap_col_nxt  = {color_r, color_g, color_b};
      addr_nxt     = 8'd0;
      rgb_nxt      = pix(mode, {color_r, color_g, color_b}, 8'd0, position);
      load_nxt     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      cap_mode   <= 2'd0;
      cap_col    <= 24'd0;
      address    <= 8'd0;
      red        <= 8'd0;
      green      <= 8'd0;
      blue       <= 8'd0;
      load       <= 1'b0;
      latch_n    <= 1'b1;
      position   <= 8'd0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      cap_mode   <= cap_mode_nxt;
      cap_col    <= cap_col_nxt;
      address    <= addr_nxt;
      {red, green, blue} <= rgb_nxt;
      load       <= load_nxt;
      latch_n    <= latch_nxt;
      position   <= pos_nxt;
      frame_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_ws2812b_ring_animator.sv
// Directed bench for ws2812b_ring_animator, NB_LEDS=4, period 16.
// Tail expectations follow WS2812B_TAIL_EN when it is defined.
module tb_ws2812b_ring_animator;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] color_r = 8'd0;
  logic [7:0] color_g = 8'd0;
  logic [7:0] color_b = 8'd0;
  logic [7:0] address, red, green, blue, position;
  logic       load, latch_n, frame_done;

  int errors = 0;
  int checks = 0;
  logic [23:0] fr [4];
  logic [7:0]  fpos;

  always #5 clk = ~clk;

  ws2812b_ring_animator #(
    .NB_LEDS(4),
    .FRAME_PERIOD_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .color_r(color_r), .color_g(color_g), .color_b(color_b),
    .address(address), .red(red), .green(green), .blue(blue),
    .load(load), .latch_n(latch_n), .position(position),
    .frame_done(frame_done)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_load();
    int n = 0;
    while (load !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("load_seen", {31'd0, load}, 32'd1);
  endtask

  task automatic grab(input int chg_at, input logic [23:0] new_c);
    wait_load();
    fpos = position;
    for (int i = 0; i < 4; i++) begin
      check("load_addr", {24'd0, address}, i);
      fr[i] = {red, green, blue};
      if (i == chg_at) {color_r, color_g, color_b} = new_c;
      @(negedge clk);
    end
  endtask

  initial begin
    int k;
    int lat_k, done_k, cnt;
    logic [23:0] e;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_latch_n", {31'd0, latch_n}, 32'd1);
    check("rst_load", {31'd0, load}, 32'd0);
    check("rst_pos", {24'd0, position}, 32'd0);
    check("rst_addr", {24'd0, address}, 32'd0);
    check("rst_rgb", {8'd0, red, green, blue}, 32'd0);
    check("rst_done", {31'd0, frame_done}, 32'd0);

    // solid frame and frame period
    mode = 2'd2;
    {color_r, color_g, color_b} = 24'h33_44_55;
    enable = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("sol_load", {31'd0, load}, 32'd1);
      check("sol_addr", {24'd0, address}, i);
      check("sol_rgb", {8'd0, red, green, blue}, 32'h33_44_55);
      @(negedge clk);
    end
    check("gap_load", {31'd0, load}, 32'd0);
    check("gap_latch", {31'd0, latch_n}, 32'd1);
    check("gap_addr", {24'd0, address}, 32'd3);
    @(negedge clk);
    check("latch_low", {31'd0, latch_n}, 32'd0);
    @(negedge clk);
    check("latch_hi", {31'd0, latch_n}, 32'd1);
    check("done_pulse", {31'd0, frame_done}, 32'd1);
    check("pos_adv", {24'd0, position}, 32'd1);
    k = 6;
    do begin
      @(negedge clk);
      k++;
      if (k == 7) check("done_drop", {31'd0, frame_done}, 32'd0);
    end while (load !== 1'b1 && k < 40);
    check("period", k, 32'd16);

    // chase wrap over 5 frames
    reset = 1'b1;
    mode = 2'd0;
    {color_r, color_g, color_b} = 24'hFF_00_00;
    @(negedge clk);
    reset = 1'b0;
    for (int f = 0; f < 5; f++) begin
      grab(-1, 24'd0);
      check("chase_pos", {24'd0, fpos}, f % 4);
      for (int a = 0; a < 4; a++) begin
        e = 24'd0;
        if (a == f % 4) e = 24'hFF_00_00;
`ifdef WS2812B_TAIL_EN
        else if (a == (f + 3) % 4) e = 24'h7F_00_00;
        else if (a == (f + 2) % 4) e = 24'h3F_00_00;
`endif
        check("chase_px", {8'd0, fr[a]}, {8'd0, e});
      end
    end

    // fill with colour change in the p=2 frame
    reset = 1'b1;
    mode = 2'd1;
    {color_r, color_g, color_b} = 24'hAA_BB_CC;
    @(negedge clk);
    reset = 1'b0;
    for (int f = 0; f < 4; f++) begin
      grab(f == 2 ? 0 : -1, 24'h11_22_33);
      for (int a = 0; a < 4; a++) begin
        e = 24'd0;
        if (a <= f) e = (f == 3) ? 24'h11_22_33 : 24'hAA_BB_CC;
        check("fill_px", {8'd0, fr[a]}, {8'd0, e});
      end
    end

    // drop enable mid-LOAD
    reset = 1'b1;
    mode = 2'd2;
    {color_r, color_g, color_b} = 24'h01_02_03;
    @(negedge clk);
    reset = 1'b0;
    wait_load();
    enable = 1'b0;
    lat_k = -1;
    done_k = -1;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      if (latch_n === 1'b0) lat_k = j;
      if (frame_done === 1'b1) done_k = j;
    end
    check("dis_latch_at", lat_k, 32'd5);
    check("dis_done_at", done_k, 32'd6);
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (load === 1'b1) cnt++;
    end
    check("dis_no_load", cnt, 32'd0);
    check("dis_pos_kept", {24'd0, position}, 32'd1);
    check("idle_addr", {24'd0, address}, 32'd0);
    check("idle_rgb", {8'd0, red, green, blue}, 32'd0);

    // reset mid-LOAD
    enable = 1'b1;
    wait_load();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rmid_load", {31'd0, load}, 32'd0);
    check("rmid_addr", {24'd0, address}, 32'd0);
    check("rmid_pos", {24'd0, position}, 32'd0);
    reset = 1'b0;
    enable = 1'b0;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (latch_n === 1'b0) cnt++;
    end
    check("rmid_no_latch", cnt, 32'd0);

`ifdef WS2812B_TAIL_EN
    // tail wraps past LED 0
    reset = 1'b1;
    mode = 2'd0;
    {color_r, color_g, color_b} = 24'h80_80_80;
    enable = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    grab(-1, 24'd0);
    check("tail_0", {8'd0, fr[0]}, 32'h80_80_80);
    check("tail_1", {8'd0, fr[1]}, 32'h00_00_00);
    check("tail_2", {8'd0, fr[2]}, 32'h20_20_20);
    check("tail_3", {8'd0, fr[3]}, 32'h40_40_40);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
